// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: bus width defaults, command encodings
// ({cs_n,ras_n,cas_n,we_n}), arbiter state type and grant vector type.
package sdram_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned BANK_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_t;

  // One-hot engine selection produced by the priority picker.
  typedef struct packed {
    logic aref;
    logic wr;
    logic rd;
  } arb_grant_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational priority picker for the SDRAM arbiter.
// Refresh always wins; write and read alternate when both are pending.
// Ports:
//   aref_req_i  refresh pending
//   wr_req_i    write pending
//   rd_req_i    read pending
//   last_wr_i   1 if the most recent write/read grant was a write
//   grant_o     one-hot selection (all zero when nothing is pending)
module sdram_arb_pick
  import sdram_pkg::*;
(
  input  logic       aref_req_i,
  input  logic       wr_req_i,
  input  logic       rd_req_i,
  input  logic       last_wr_i,
  output arb_grant_t grant_o
);

  always_comb begin
    grant_o = '0;
    if (aref_req_i) begin
      grant_o.aref = 1'b1;
    end else if (wr_req_i && rd_req_i) begin
      // Both pending: serve whichever was not served last.
      if (last_wr_i) grant_o.rd = 1'b1;
      else           grant_o.wr = 1'b1;
    end else if (wr_req_i) begin
      grant_o.wr = 1'b1;
    end else if (rd_req_i) begin
      grant_o.rd = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter. Holds the command/address/data bus for the init
// engine until init_end, then grants refresh, write or read one at a time
// with at least one NOP cycle between grants.
// Ports:
//   arb_clk, arb_rst            clock, synchronous active-high reset
//   init_end, init_*            init engine status and bus
//   aref_req/end/cmd/bank/addr  refresh engine handshake and bus; aref_en grant
//   wr_req/end/cmd/bank/addr    write engine handshake and bus; wr_en grant
//   wr_sdram_en/wr_sdram_data   write data and DQ drive enable
//   rd_req/end/cmd/bank/addr    read engine handshake and bus; rd_en grant
//   sdram_cmd/bank/addr         SDRAM pins
//   sdram_dq_o/sdram_dq_oe      DQ value and output enable
module sdram_arbiter #(
  parameter int unsigned ADDR_W  = sdram_pkg::ADDR_W_DEF,
  parameter int unsigned BANK_W  = sdram_pkg::BANK_W_DEF,
  parameter int unsigned DATA_W  = sdram_pkg::DATA_W_DEF,
  parameter logic [3:0]  CMD_NOP = sdram_pkg::CMD_NOP
) (
  input  logic              arb_clk,
  input  logic              arb_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_o,
  output logic              sdram_dq_oe
);

  import sdram_pkg::*;

  arb_state_t state_q, state_d;
  logic       aref_en_q, wr_en_q, rd_en_q;
  logic       last_wr_q, last_wr_d;
  arb_grant_t pick;

  sdram_arb_pick u_pick (
    .aref_req_i (aref_req),
    .wr_req_i   (wr_req),
    .rd_req_i   (rd_req),
    .last_wr_i  (last_wr_q),
    .grant_o    (pick)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    if (!init_end) begin
      // Losing init_end from any state hands the bus back to init.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_ARB;
        ST_ARB: begin
          if      (pick.aref) state_d = ST_AREF;
          else if (pick.wr)   state_d = ST_WRITE;
          else if (pick.rd)   state_d = ST_READ;
        end
        ST_AREF:  if (aref_end) state_d = ST_ARB;
        ST_WRITE: if (wr_end)   state_d = ST_ARB;
        ST_READ:  if (rd_end)   state_d = ST_ARB;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (state_q == ST_ARB && state_d == ST_WRITE) last_wr_d = 1'b1;
    if (state_q == ST_ARB && state_d == ST_READ)  last_wr_d = 1'b0;
  end

  // Grants are registered copies of the next state so they rise and fall
  // on the same edge as the state change.
  always_ff @(posedge arb_clk) begin
    if (arb_rst) begin
      state_q   <= ST_IDLE;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
      last_wr_q <= last_wr_d;
    end
  end

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_bank  = '1;
    sdram_addr  = '1;
    sdram_dq_o  = '0;
    sdram_dq_oe = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_bank = aref_bank;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_bank  = wr_bank;
        sdram_addr  = wr_addr;
        sdram_dq_o  = wr_sdram_data;
        sdram_dq_oe = wr_sdram_en;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int AW = 13;
  localparam int BW = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [BW-1:0] init_bank;
  logic [AW-1:0] init_addr;
  logic          aref_req, aref_end, aref_en;
  logic [3:0]    aref_cmd;
  logic [BW-1:0] aref_bank;
  logic [AW-1:0] aref_addr;
  logic          wr_req, wr_end, wr_en, wr_sdram_en;
  logic [3:0]    wr_cmd;
  logic [BW-1:0] wr_bank;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_sdram_data;
  logic          rd_req, rd_end, rd_en;
  logic [3:0]    rd_cmd;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;
  logic [3:0]    sdram_cmd;
  logic [BW-1:0] sdram_bank;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_dq_o;
  logic          sdram_dq_oe;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .CMD_NOP(4'b0111)) dut (
    .arb_clk(clk), .arb_rst(rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank(aref_bank), .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .wr_en(wr_en), .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, and whether the last data grant was a write.
  localparam int OWN_INIT = 0, OWN_GAP = 1, OWN_REFRESH = 2, OWN_WRITER = 3, OWN_READER = 4;
  int owner = OWN_INIT;
  bit prev_was_write = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the arbitration rules to the inputs sampled at this edge.
  task automatic model_edge();
    if (rst) begin
      owner = OWN_INIT;
      prev_was_write = 1'b0;
    end else if (!init_end) begin
      owner = OWN_INIT;
    end else if (owner == OWN_INIT) begin
      owner = OWN_GAP;
    end else if (owner == OWN_GAP) begin
      if (aref_req) owner = OWN_REFRESH;
      else if (wr_req && (!rd_req || !prev_was_write)) owner = OWN_WRITER;
      else if (rd_req) owner = OWN_READER;
      if (owner == OWN_WRITER) prev_was_write = 1'b1;
      if (owner == OWN_READER) prev_was_write = 1'b0;
    end else if ((owner == OWN_REFRESH && aref_end) ||
                 (owner == OWN_WRITER && wr_end) ||
                 (owner == OWN_READER && rd_end)) begin
      owner = OWN_GAP;
    end
  endtask

  task automatic check_model();
    logic [3:0]    e_cmd;
    logic [BW-1:0] e_bank;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dq;
    logic          e_oe;
    e_cmd = 4'b0111; e_bank = '1; e_addr = '1; e_dq = '0; e_oe = 1'b0;
    case (owner)
      OWN_INIT:    begin e_cmd = init_cmd; e_bank = init_bank; e_addr = init_addr; end
      OWN_REFRESH: begin e_cmd = aref_cmd; e_bank = aref_bank; e_addr = aref_addr; end
      OWN_WRITER:  begin e_cmd = wr_cmd; e_bank = wr_bank; e_addr = wr_addr;
                         e_dq = wr_sdram_data; e_oe = wr_sdram_en; end
      OWN_READER:  begin e_cmd = rd_cmd; e_bank = rd_bank; e_addr = rd_addr; end
      default: ;
    endcase
    chk("aref_en", 32'(aref_en), 32'(owner == OWN_REFRESH));
    chk("wr_en",   32'(wr_en),   32'(owner == OWN_WRITER));
    chk("rd_en",   32'(rd_en),   32'(owner == OWN_READER));
    chk("cmd",     32'(sdram_cmd),  32'(e_cmd));
    chk("bank",    32'(sdram_bank), 32'(e_bank));
    chk("addr",    32'(sdram_addr), 32'(e_addr));
    chk("dq_o",    32'(sdram_dq_o), 32'(e_dq));
    chk("dq_oe",   32'(sdram_dq_oe), 32'(e_oe));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic rand_buses();
    init_cmd = 4'($urandom); init_bank = BW'($urandom); init_addr = AW'($urandom);
    aref_cmd = 4'($urandom); aref_bank = BW'($urandom); aref_addr = AW'($urandom);
    wr_cmd   = 4'($urandom); wr_bank   = BW'($urandom); wr_addr   = AW'($urandom);
    rd_cmd   = 4'($urandom); rd_bank   = BW'($urandom); rd_addr   = AW'($urandom);
    wr_sdram_data = DW'($urandom); wr_sdram_en = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; init_end = 1'b0;
    aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    rand_buses();
    wr_sdram_en = 1'b0;
    init_cmd = 4'b0010;

    // T1: reset with init pending
    repeat (5) tick();
    chk("t1_cmd", 32'(sdram_cmd), 32'h2);
    chk("t1_oe", 32'(sdram_dq_oe), 32'h0);
    rst = 1'b0;
    tick();
    chk("t1_idle_cmd", 32'(sdram_cmd), 32'h2);

    // T2: IDLE -> ARB -> WRITE, then data pass-through and release
    init_end = 1'b1; wr_req = 1'b1;
    tick();
    chk("t2_gap_wr_en", 32'(wr_en), 32'h0);
    chk("t2_gap_cmd", 32'(sdram_cmd), 32'h7);
    tick();
    chk("t2_wr_en", 32'(wr_en), 32'h1);
    wr_req = 1'b0; wr_sdram_en = 1'b1; wr_sdram_data = 16'h00A5;
    tick();
    chk("t2_dq", 32'(sdram_dq_o), 32'h00A5);
    chk("t2_oe", 32'(sdram_dq_oe), 32'h1);
    wr_end = 1'b1;
    tick();
    wr_end = 1'b0;
    chk("t2_release", 32'(wr_en), 32'h0);
    chk("t2_nop", 32'(sdram_cmd), 32'h7);

    // T3: both held -> READ first (last was write), alternating with one gap cycle
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_grant_rd", 32'(rd_en), 32'((k % 2) == 0));
      chk("t3_grant_wr", 32'(wr_en), 32'((k % 2) == 1));
      tick();
      if ((k % 2) == 0) rd_end = 1'b1; else wr_end = 1'b1;
      tick();
      rd_end = 1'b0; wr_end = 1'b0;
      chk("t3_gap_cmd", 32'(sdram_cmd), 32'h7);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // T4: refresh raised mid-write while read pending
    wr_req = 1'b1;
    tick();
    chk("t4_wr", 32'(wr_en), 32'h1);
    wr_req = 1'b0; aref_req = 1'b1; rd_req = 1'b1;
    repeat (3) tick();
    chk("t4_no_abort", 32'(wr_en), 32'h1);
    wr_end = 1'b1; tick(); wr_end = 1'b0;
    tick();
    chk("t4_aref", 32'(aref_en), 32'h1);
    aref_req = 1'b0;
    aref_end = 1'b1; tick(); aref_end = 1'b0;
    tick();
    chk("t4_rd", 32'(rd_en), 32'h1);

    // T5: reset pulse during READ
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rd_drop", 32'(rd_en), 32'h0);
    chk("t5_cmd", 32'(sdram_cmd), 32'(init_cmd));
    rd_req = 1'b0;
    tick();

    // T6: init_end dropped during refresh
    aref_req = 1'b1; tick();
    chk("t6_aref", 32'(aref_en), 32'h1);
    init_end = 1'b0; wr_req = 1'b1; tick();
    chk("t6_drop", 32'(aref_en), 32'h0);
    chk("t6_cmd", 32'(sdram_cmd), 32'(init_cmd));
    repeat (3) tick();
    chk("t6_no_grant", 32'({aref_en, wr_en, rd_en}), 32'h0);
    init_end = 1'b1; aref_req = 1'b0; wr_req = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rand_buses();
      aref_req = ($urandom_range(0, 7) == 0);
      wr_req   = ($urandom_range(0, 1) == 0);
      rd_req   = ($urandom_range(0, 1) == 0);
      aref_end = ($urandom_range(0, 3) == 0);
      wr_end   = ($urandom_range(0, 3) == 0);
      rd_end   = ($urandom_range(0, 3) == 0);
      init_end = ($urandom_range(0, 63) != 0);
      rst      = ($urandom_range(0, 127) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
